// File: rtl/wdt_supervisor_if.sv
// Heartbeat supervisor bus: supervision controls and heartbeat strobes in,
// WDT drive and fault status out.
interface wdt_supervisor_if #(
    parameter int N_SRC = 4
);
    logic             tick_1khz;
    logic             arm;
    logic [N_SRC-1:0] src_mask;
    logic [N_SRC-1:0] hb_in;
    logic             wdt_kick;
    logic             wdt_en;
    logic             fault;
    logic [N_SRC-1:0] fault_src;
    logic [15:0]      kick_count;

    modport master (
        output tick_1khz, arm, src_mask, hb_in,
        input  wdt_kick, wdt_en, fault, fault_src, kick_count
    );

    modport slave (
        input  tick_1khz, arm, src_mask, hb_in,
        output wdt_kick, wdt_en, fault, fault_src, kick_count
    );
endinterface

// File: rtl/wdt_supervisor.sv
// Heartbeat supervisor: toggles the WDT kick only once every enabled source has
// checked in during a window; MAX_MISS consecutive incomplete windows latch a fault.
module wdt_supervisor #(
    parameter int          N_SRC     = 4,
    parameter logic [15:0] WINDOW_MS = 16'd20,
    parameter logic [3:0]  MAX_MISS  = 4'd3
) (
    input logic             clk,
    input logic             rst,
    wdt_supervisor_if.slave sup
);
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        KICK    = 2'd2,
        FAULT   = 2'd3
    } state_t;

    state_t           state_r, state_nxt;
    logic [N_SRC-1:0] seen_r, seen_nxt;
    logic [N_SRC-1:0] active_mask_r, active_mask_nxt;
    logic [N_SRC-1:0] fault_src_r, fault_src_nxt;
    logic [15:0]      win_cnt_r, win_cnt_nxt;
    logic [15:0]      kick_count_r, kick_count_nxt;
    logic [3:0]       miss_cnt_r, miss_cnt_nxt;
    logic             kick_r, kick_nxt;
    logic             fault_r, fault_nxt;
    logic             en_r;
    logic [N_SRC-1:0] hit_s;
    logic             win_end_s;

    assign hit_s     = seen_r | (sup.hb_in & active_mask_r);
    assign win_end_s = sup.tick_1khz && (win_cnt_r == (WINDOW_MS - 16'd1));

    // Next-state and datapath decisions; every register holds unless a state acts on it.
    always_comb begin
        state_nxt       = state_r;
        seen_nxt        = seen_r;
        active_mask_nxt = active_mask_r;
        fault_src_nxt   = fault_src_r;
        win_cnt_nxt     = win_cnt_r;
        kick_count_nxt  = kick_count_r;
        miss_cnt_nxt    = miss_cnt_r;
        kick_nxt        = kick_r;
        fault_nxt       = fault_r;
        case (state_r)
            IDLE: begin
                if (sup.arm && (sup.src_mask != {N_SRC{1'b0}})) begin
                    active_mask_nxt = sup.src_mask;
                    seen_nxt        = {N_SRC{1'b0}};
                    win_cnt_nxt     = 16'd0;
                    miss_cnt_nxt    = 4'd0;
                    fault_nxt       = 1'b0;
                    fault_src_nxt   = {N_SRC{1'b0}};
                    kick_count_nxt  = 16'd0;
                    state_nxt       = COLLECT;
                end else begin
                    state_nxt = IDLE;
                end
            end
            COLLECT: begin
                if (!sup.arm) begin
                    seen_nxt    = {N_SRC{1'b0}};
                    win_cnt_nxt = 16'd0;
                    state_nxt   = IDLE;
                end else if (hit_s == active_mask_r) begin
                    // Completion wins over a window expiring on the same tick.
                    seen_nxt    = hit_s;
                    win_cnt_nxt = 16'd0;
                    state_nxt   = KICK;
                end else if (win_end_s) begin
                    if ((miss_cnt_r + 4'd1) == MAX_MISS) begin
                        fault_nxt     = 1'b1;
                        fault_src_nxt = active_mask_r & ~hit_s;
                        state_nxt     = FAULT;
                    end else begin
                        miss_cnt_nxt = miss_cnt_r + 4'd1;
                        seen_nxt     = {N_SRC{1'b0}};
                        win_cnt_nxt  = 16'd0;
                    end
                end else begin
                    seen_nxt    = hit_s;
                    win_cnt_nxt = win_cnt_r + {15'd0, sup.tick_1khz};
                end
            end
            KICK: begin
                if (!sup.arm) begin
                    seen_nxt    = {N_SRC{1'b0}};
                    win_cnt_nxt = 16'd0;
                    state_nxt   = IDLE;
                end else begin
                    // Heartbeats arriving during the kick cycle belong to the next window.
                    kick_nxt       = ~kick_r;
                    kick_count_nxt = kick_count_r + 16'd1;
                    miss_cnt_nxt   = 4'd0;
                    win_cnt_nxt    = 16'd0;
                    seen_nxt       = sup.hb_in & active_mask_r;
                    state_nxt      = COLLECT;
                end
            end
            FAULT: begin
                if (!sup.arm) begin
                    seen_nxt    = {N_SRC{1'b0}};
                    win_cnt_nxt = 16'd0;
                    state_nxt   = IDLE;
                end else begin
                    state_nxt = FAULT;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r       <= IDLE;
            seen_r        <= {N_SRC{1'b0}};
            active_mask_r <= {N_SRC{1'b0}};
            fault_src_r   <= {N_SRC{1'b0}};
            win_cnt_r     <= 16'd0;
            kick_count_r  <= 16'd0;
            miss_cnt_r    <= 4'd0;
            kick_r        <= 1'b0;
            fault_r       <= 1'b0;
            en_r          <= 1'b0;
        end else begin
            state_r       <= state_nxt;
            seen_r        <= seen_nxt;
            active_mask_r <= active_mask_nxt;
            fault_src_r   <= fault_src_nxt;
            win_cnt_r     <= win_cnt_nxt;
            kick_count_r  <= kick_count_nxt;
            miss_cnt_r    <= miss_cnt_nxt;
            kick_r        <= kick_nxt;
            fault_r       <= fault_nxt;
            en_r          <= (state_nxt != IDLE);
        end
    end

    assign sup.wdt_kick   = kick_r;
    assign sup.wdt_en     = en_r;
    assign sup.fault      = fault_r;
    assign sup.fault_src  = fault_src_r;
    assign sup.kick_count = kick_count_r;
endmodule

// File: tb/tb_wdt_supervisor.sv
// Self-checking bench for wdt_supervisor: directed scenarios plus randomized traffic
// compared against a window/miss reference model.
module tb_wdt_supervisor;
    localparam int WIN  = 20;
    localparam int MAXM = 3;
    localparam int M_IDLE = 0, M_COLLECT = 1, M_KICK = 2, M_FAULT = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;

    wdt_supervisor_if #(.N_SRC(4)) sup();

    wdt_supervisor #(.N_SRC(4), .WINDOW_MS(16'd20), .MAX_MISS(4'd3)) dut (
        .clk (clk),
        .rst (rst),
        .sup (sup)
    );

    always #5 clk = ~clk;

    // Reference model: which sources have reported in the current window, how many
    // ticks the window has used, and how many windows in a row went incomplete.
    int          m_mode   = M_IDLE;
    logic [3:0]  m_mask   = 4'b0000;
    logic [3:0]  m_seen   = 4'b0000;
    logic [3:0]  m_fsrc   = 4'b0000;
    int          m_ticks  = 0;
    int          m_misses = 0;
    logic [15:0] m_kicks  = 16'd0;
    logic        m_kick   = 1'b0;
    logic        m_fault  = 1'b0;
    logic        cur_arm  = 1'b0;
    logic [3:0]  cur_mask = 4'b0000;

    task automatic model_update(input logic r, input logic a, input logic [3:0] m,
                                input logic t, input logic [3:0] h);
        logic [3:0] got;
        if (r) begin
            m_mode = M_IDLE; m_mask = 4'b0000; m_seen = 4'b0000; m_fsrc = 4'b0000;
            m_ticks = 0; m_misses = 0; m_kicks = 16'd0; m_kick = 1'b0; m_fault = 1'b0;
        end else if (m_mode != M_IDLE && !a) begin
            m_mode = M_IDLE; m_seen = 4'b0000; m_ticks = 0;
        end else if (m_mode == M_IDLE) begin
            if (a && m != 4'b0000) begin
                m_mask = m; m_seen = 4'b0000; m_ticks = 0; m_misses = 0;
                m_fault = 1'b0; m_fsrc = 4'b0000; m_kicks = 16'd0; m_mode = M_COLLECT;
            end
        end else if (m_mode == M_KICK) begin
            m_kick = ~m_kick; m_kicks = m_kicks + 16'd1; m_misses = 0; m_ticks = 0;
            m_seen = h & m_mask; m_mode = M_COLLECT;
        end else if (m_mode == M_COLLECT) begin
            got = m_seen | (h & m_mask);
            if (got == m_mask) begin
                m_mode = M_KICK; m_ticks = 0;
            end else if (t && (m_ticks + 1 == WIN)) begin
                if (m_misses + 1 == MAXM) begin
                    m_fault = 1'b1; m_fsrc = m_mask & ~got; m_mode = M_FAULT;
                end else begin
                    m_misses++; m_seen = 4'b0000; m_ticks = 0;
                end
            end else begin
                m_seen = got; m_ticks = m_ticks + (t ? 1 : 0);
            end
        end
    endtask

    task automatic step(input logic r, input logic a, input logic [3:0] m,
                        input logic t, input logic [3:0] h);
        rst = r; sup.arm = a; sup.src_mask = m; sup.tick_1khz = t; sup.hb_in = h;
        model_update(r, a, m, t, h);
        @(posedge clk);
        #1;
    endtask

    // One millisecond: tick on the first cycle, heartbeat pattern on the second.
    task automatic do_ms(input logic [3:0] h);
        step(1'b0, cur_arm, cur_mask, 1'b1, 4'b0000);
        step(1'b0, cur_arm, cur_mask, 1'b0, h);
        step(1'b0, cur_arm, cur_mask, 1'b0, 4'b0000);
        step(1'b0, cur_arm, cur_mask, 1'b0, 4'b0000);
    endtask

    task automatic start(input logic [3:0] m);
        cur_arm = 1'b0; cur_mask = m;
        step(1'b1, 1'b0, 4'b0000, 1'b0, 4'b0000);
        cur_arm = 1'b1;
        step(1'b0, cur_arm, cur_mask, 1'b0, 4'b0000);
    endtask

    task automatic test_reset();
        step(1'b1, 1'b1, 4'b1111, 1'b1, 4'b1111);
        n_checks++;
        if ({sup.wdt_kick, sup.wdt_en, sup.fault, sup.fault_src, sup.kick_count} !== 23'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: kick=%b en=%b fault=%b src=%b cnt=%0d, required all zero",
                     sup.wdt_kick, sup.wdt_en, sup.fault, sup.fault_src, sup.kick_count);
        end
    endtask

    task automatic test_single_window();
        start(4'b1011);
        n_checks++;
        if (sup.wdt_en !== 1'b1) begin
            n_fail++; $display("FAIL arm_enable: wdt_en=%b required 1", sup.wdt_en);
        end
        for (int ms = 1; ms <= 8; ms++)
            do_ms(ms == 2 ? 4'b0001 : (ms == 5 ? 4'b0010 : 4'b0000));
        step(1'b0, 1'b1, 4'b1011, 1'b1, 4'b0000);
        step(1'b0, 1'b1, 4'b1011, 1'b0, 4'b1000);
        n_checks++;
        if (sup.wdt_kick !== 1'b0) begin
            n_fail++; $display("FAIL kick_latency_early: wdt_kick=%b required 0", sup.wdt_kick);
        end
        step(1'b0, 1'b1, 4'b1011, 1'b0, 4'b0000);
        n_checks++;
        if (sup.wdt_kick !== 1'b1 || sup.kick_count !== 16'd1) begin
            n_fail++;
            $display("FAIL first_kick: wdt_kick=%b kick_count=%0d required 1 and 1",
                     sup.wdt_kick, sup.kick_count);
        end
    endtask

    task automatic test_ten_windows();
        logic prev;
        int   toggles;
        int   bad;
        start(4'b1011);
        toggles = 0; bad = 0; prev = sup.wdt_kick;
        for (int w = 0; w < 10; w++) begin
            for (int ms = 1; ms <= 12; ms++) begin
                do_ms(ms == 2 ? 4'b0001 : (ms == 5 ? 4'b0010 : (ms == 9 ? 4'b1000 : 4'b0000)));
                if (sup.fault !== 1'b0 || sup.wdt_en !== 1'b1) bad++;
                if (sup.wdt_kick !== prev) toggles++;
                prev = sup.wdt_kick;
            end
        end
        n_checks++;
        if (toggles != 10 || sup.kick_count !== 16'd10) begin
            n_fail++;
            $display("FAIL ten_windows: toggles=%0d kick_count=%0d required 10 and 10",
                     toggles, sup.kick_count);
        end
        n_checks++;
        if (bad != 0) begin
            n_fail++; $display("FAIL ten_windows_status: %0d samples with fault!=0 or en!=1, required 0", bad);
        end
    endtask

    task automatic test_fault();
        start(4'b1011);
        for (int ms = 1; ms <= 3 * WIN; ms++) begin
            do_ms(4'b0011);
            n_checks++;
            if (sup.fault !== ((ms == 3 * WIN) ? 1'b1 : 1'b0)) begin
                n_fail++; $display("FAIL fault_timing: ms=%0d fault=%b required %b",
                                   ms, sup.fault, (ms == 3 * WIN));
            end
        end
        n_checks++;
        if (sup.fault_src !== 4'b1000) begin
            n_fail++; $display("FAIL fault_src: got %b required 1000", sup.fault_src);
        end
        for (int ms = 0; ms < 5; ms++) do_ms(4'b1111);
        n_checks++;
        if (sup.wdt_kick !== 1'b0 || sup.kick_count !== 16'd0 || sup.fault !== 1'b1) begin
            n_fail++; $display("FAIL fault_frozen: kick=%b cnt=%0d fault=%b required 0, 0, 1",
                               sup.wdt_kick, sup.kick_count, sup.fault);
        end
        step(1'b0, 1'b0, 4'b1011, 1'b0, 4'b0000);
        n_checks++;
        if (sup.wdt_en !== 1'b0 || sup.fault !== 1'b1 || sup.fault_src !== 4'b1000) begin
            n_fail++; $display("FAIL disarm_after_fault: en=%b fault=%b src=%b required 0, 1, 1000",
                               sup.wdt_en, sup.fault, sup.fault_src);
        end
    endtask

    task automatic test_miss_recovery();
        start(4'b1011);
        for (int ms = 0; ms < 2 * WIN; ms++) do_ms(4'b0011);
        do_ms(4'b1011);
        n_checks++;
        if (sup.fault !== 1'b0 || sup.kick_count !== 16'd1) begin
            n_fail++; $display("FAIL recovery_kick: fault=%b cnt=%0d required 0 and 1",
                               sup.fault, sup.kick_count);
        end
        for (int ms = 0; ms < 2 * WIN; ms++) do_ms(4'b0011);
        n_checks++;
        if (sup.fault !== 1'b0) begin
            n_fail++; $display("FAIL miss_cleared_by_kick: fault=%b required 0", sup.fault);
        end
        for (int ms = 0; ms < WIN; ms++) do_ms(4'b0011);
        n_checks++;
        if (sup.fault !== 1'b1 || sup.fault_src !== 4'b1000) begin
            n_fail++; $display("FAIL third_miss_fault: fault=%b src=%b required 1 and 1000",
                               sup.fault, sup.fault_src);
        end
    endtask

    task automatic test_completion_on_expiry();
        start(4'b1011);
        do_ms(4'b0011);
        for (int ms = 2; ms < WIN; ms++) do_ms(4'b0000);
        step(1'b0, 1'b1, 4'b1011, 1'b1, 4'b1000);
        step(1'b0, 1'b1, 4'b1011, 1'b0, 4'b0000);
        n_checks++;
        if (sup.wdt_kick !== 1'b1 || sup.kick_count !== 16'd1 || sup.fault !== 1'b0) begin
            n_fail++; $display("FAIL completion_beats_expiry: kick=%b cnt=%0d fault=%b required 1, 1, 0",
                               sup.wdt_kick, sup.kick_count, sup.fault);
        end
    endtask

    task automatic test_rst_mid_collect();
        start(4'b1011);
        do_ms(4'b0011);
        step(1'b1, 1'b1, 4'b1011, 1'b1, 4'b1000);
        n_checks++;
        if ({sup.wdt_kick, sup.wdt_en, sup.fault, sup.fault_src, sup.kick_count} !== 23'd0) begin
            n_fail++; $display("FAIL rst_mid_collect: en=%b kick=%b, required all outputs zero",
                               sup.wdt_en, sup.wdt_kick);
        end
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 4'b0000, 1'b1, 4'b1111);
        n_checks++;
        if (sup.wdt_en !== 1'b0) begin
            n_fail++; $display("FAIL empty_mask_idle: wdt_en=%b required 0", sup.wdt_en);
        end
        // A nonzero mask must now be accepted; the stale seen bits must not carry over.
        step(1'b0, 1'b1, 4'b1011, 1'b0, 4'b1000);
        step(1'b0, 1'b1, 4'b1011, 1'b0, 4'b0000);
        step(1'b0, 1'b1, 4'b1011, 1'b0, 4'b0000);
        n_checks++;
        if (sup.wdt_en !== 1'b1 || sup.kick_count !== 16'd0) begin
            n_fail++; $display("FAIL rearm_after_rst: en=%b cnt=%0d required 1 and 0",
                               sup.wdt_en, sup.kick_count);
        end
    endtask

    task automatic test_random();
        logic [3:0] m, dead, h, one;
        logic       a, t, r;
        int         errs;
        one = 4'b0001; dead = 4'b0000; a = 1'b1; errs = 0;
        step(1'b1, 1'b0, 4'b0000, 1'b0, 4'b0000);
        for (int i = 0; i < 6000; i++) begin
            if (i % 400 == 0)
                dead = ($urandom_range(0, 2) == 0) ? (one << $urandom_range(0, 3)) : 4'b0000;
            if (a && $urandom_range(0, 299) == 0) a = 1'b0;
            else if (!a && $urandom_range(0, 7) == 0) a = 1'b1;
            m = 4'($urandom_range(0, 15));
            r = ($urandom_range(0, 1999) == 0);
            t = ($urandom_range(0, 3) == 0);
            for (int b = 0; b < 4; b++) h[b] = ($urandom_range(0, 19) == 0) && !dead[b];
            step(r, a, m, t, h);
            n_checks++;
            if (sup.wdt_kick !== m_kick || sup.wdt_en !== (m_mode != M_IDLE) ||
                sup.fault !== m_fault || sup.fault_src !== m_fsrc || sup.kick_count !== m_kicks) begin
                n_fail++;
                if (errs < 20)
                    $display("FAIL random_cycle %0d: kick=%b en=%b fault=%b src=%b cnt=%0d required kick=%b en=%b fault=%b src=%b cnt=%0d",
                             i, sup.wdt_kick, sup.wdt_en, sup.fault, sup.fault_src, sup.kick_count,
                             m_kick, (m_mode != M_IDLE), m_fault, m_fsrc, m_kicks);
                errs++;
            end
        end
    endtask

    initial begin
        sup.arm = 1'b0; sup.src_mask = 4'b0000; sup.tick_1khz = 1'b0; sup.hb_in = 4'b0000;
        test_reset();
        test_single_window();
        test_ten_windows();
        test_fault();
        test_miss_recovery();
        test_completion_on_expiry();
        test_rst_mid_collect();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
